aes_core_arbiter: RTL and testbench

//  Shares one aes_encrypt_core (AES-128, ~11-cycle iterative T-box engine) among NREQ requesters.

---
 rtl/aes_core_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_aes_core_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter
//   Round-robin arbiter sharing one iterative AES-128 encrypt core among
//   NREQ requesters. One job in flight at a time. Key/plaintext are
//   registered on grant and held for the whole core pass. The result is
//   returned on a single tagged response port.
//
// Optional feature macro: AES_ARB_WDOG_EN
//   When defined, a BUSY-cycle watchdog is added together with the
//   WDOG_LIMIT parameter and the wdog_err_o port. A hung core pass is then
//   abandoned and the arbiter resynchronises in BOOT.
//
// Ports
//   clk, nrst       clock, asynchronous active-low reset
//   req_valid_i     per-requester request pending
//   req_ready_o     one-hot accept strobe (IDLE only)
//   req_pt_i        plaintexts, requester i at [i*128 +: 128]
//   req_key_i       keys, same packing
//   rsp_valid_o     ciphertext valid, held until rsp_ready_i
//   rsp_ready_i     response consumer ready
//   rsp_id_o        requester that owns rsp_data_o
//   rsp_data_o      ciphertext
//   core_start_o    core start pulse (one cycle)
//   core_pt_o       plaintext to core (registered)
//   core_key_o      key to core (registered)
//   core_ct_i       ciphertext from core
//   core_finish_i   core idle / result ready
//   wdog_err_o      sticky watchdog error (AES_ARB_WDOG_EN only)

module aes_core_arbiter #(
    parameter int NREQ = 4
`ifdef AES_ARB_WDOG_EN
    ,parameter int WDOG_LIMIT = 20
`endif
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [NREQ-1:0]        req_valid_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic [NREQ*128-1:0]    req_pt_i,
    input  logic [NREQ*128-1:0]    req_key_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [$clog2(NREQ)-1:0] rsp_id_o,
    output logic [127:0]           rsp_data_o,
    output logic                   core_start_o,
    output logic [127:0]           core_pt_o,
    output logic [127:0]           core_key_o,
    input  logic [127:0]           core_ct_i,
    input  logic                   core_finish_i
`ifdef AES_ARB_WDOG_EN
    ,output logic                  wdog_err_o
`endif
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_RESP
    } state_e;

    state_e               state_q;
    logic [IDW-1:0]       rr_ptr_q;
    logic [IDW-1:0]       rsp_id_q;
    logic                 rsp_valid_q;
    logic [127:0]         rsp_data_q;
    logic                 core_start_q;
    logic [127:0]         core_pt_q;
    logic [127:0]         core_key_q;

    logic [NREQ-1:0][127:0] pt_a;
    logic [NREQ-1:0][127:0] key_a;

    assign pt_a  = req_pt_i;
    assign key_a = req_key_i;

    // Round-robin search starting just after the last granted requester.
    // cand is one bit wider so rr_ptr+k cannot overflow before the wrap.
    logic           any_req;
    logic           found;
    logic [IDW:0]   cand;
    logic [IDW-1:0] grant_d;

    always_comb begin
        any_req = |req_valid_i;
        found   = 1'b0;
        cand    = '0;
        grant_d = rr_ptr_q;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!found && req_valid_i[cand[IDW-1:0]]) begin
                found   = 1'b1;
                grant_d = cand[IDW-1:0];
            end
        end
    end

    // Accept strobe is combinational so the requester sees it in the
    // same cycle the slice is latched.
    always_comb begin
        req_ready_o = '0;
        if (state_q == S_IDLE && any_req)
            req_ready_o[grant_d] = 1'b1;
    end

`ifdef AES_ARB_WDOG_EN
    localparam int WCW = $clog2(WDOG_LIMIT + 1);
    logic [WCW-1:0] wdog_cnt_q;
    logic           wdog_err_q;
    assign wdog_err_o = wdog_err_q;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= S_BOOT;
            rr_ptr_q     <= IDW'(NREQ - 1);
            rsp_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            core_start_q <= 1'b0;
            core_pt_q    <= '0;
            core_key_q   <= '0;
`ifdef AES_ARB_WDOG_EN
            wdog_cnt_q   <= '0;
            wdog_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                // Core runs a dummy pass out of reset; its output is junk.
                S_BOOT: begin
                    if (core_finish_i)
                        state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (any_req) begin
                        core_pt_q    <= pt_a[grant_d];
                        core_key_q   <= key_a[grant_d];
                        rsp_id_q     <= grant_d;
                        rr_ptr_q     <= grant_d;
                        core_start_q <= 1'b1;
                        state_q      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    core_start_q <= 1'b0;
`ifdef AES_ARB_WDOG_EN
                    wdog_cnt_q   <= '0;
`endif
                    state_q      <= S_BUSY;
                end
                S_BUSY: begin
                    if (core_finish_i) begin
                        rsp_data_q  <= core_ct_i;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
`ifdef AES_ARB_WDOG_EN
                    else if (wdog_cnt_q == WCW'(WDOG_LIMIT - 1)) begin
                        // Drop the job; BOOT realigns on the next finish.
                        wdog_err_q <= 1'b1;
                        state_q    <= S_BOOT;
                    end else begin
                        wdog_cnt_q <= wdog_cnt_q + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_BOOT;
            endcase
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_data_o   = rsp_data_q;
    assign core_start_o = core_start_q;
    assign core_pt_o    = core_pt_q;
    assign core_key_o   = core_key_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Testbench for aes_core_arbiter: behavioural AES-128 core model plus a
// transaction-level scoreboard (round-robin order, latency, result).

module tb_aes_core_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int WDOG = 20;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0][127:0] req_pt;
    logic [NREQ-1:0][127:0] req_key;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [127:0]           rsp_data;
    logic                   core_start;
    logic [127:0]           core_pt;
    logic [127:0]           core_key;
    logic [127:0]           core_ct;
    logic                   core_finish;
`ifdef AES_ARB_WDOG_EN
    logic                   wdog_err;
`endif

    aes_core_arbiter #(.NREQ(NREQ)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_pt_i     (req_pt),
        .req_key_i    (req_key),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_data_o   (rsp_data),
        .core_start_o (core_start),
        .core_pt_o    (core_pt),
        .core_key_o   (core_key),
        .core_ct_i    (core_ct),
        .core_finish_i(core_finish)
`ifdef AES_ARB_WDOG_EN
        ,.wdog_err_o  (wdog_err)
`endif
    );

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00; aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    initial begin : sbox_init
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            b = inv;
            sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                        ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    end

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] out;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox_t[s[k]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) t[rw+4*c] = s[rw+4*((c+rw)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*r+k/4][31-8*(k%4) -: 8];
        end
        for (int k = 0; k < 16; k++) out[127-8*k -: 8] = s[k];
        return out;
    endfunction

    // ---------------- core model: 11 busy cycles per pass ----------------
    int           core_cnt;
    logic [127:0] core_res;
    logic         hang = 1'b0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            core_cnt <= 11;                 // dummy pass after reset
            core_ct  <= '0;
            core_res <= {4{32'hdeadbeef}};
        end else if (hang) begin
            core_cnt <= core_cnt;
        end else if (core_cnt == 0) begin
            if (core_start) begin
                core_cnt <= 11;
                core_res <= aes_enc(core_pt, core_key);
            end
        end else begin
            core_cnt <= core_cnt - 1;
            core_ct  <= (core_cnt == 1) ? core_res : {$urandom, $urandom, $urandom, $urandom};
        end
    end
    assign core_finish = (core_cnt == 0) && !hang;

    // ---------------- transaction scoreboard ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit             m_boot, m_busy, m_job, m_seen;
    int             m_ptr, j_id, j_t, g;
    logic [127:0]   j_pt, j_key, j_ct;
    logic [NREQ-1:0] exp_rdy;
    int             grant_log [$];

    always @(negedge clk) begin
        if (!nrst) begin
            m_boot = 1; m_busy = 1; m_job = 0; m_seen = 0; m_ptr = NREQ - 1;
        end else begin
            g = -1;
            exp_rdy = '0;
            if (!m_busy)
                for (int k = 1; k <= NREQ; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 128'(req_ready), 128'(exp_rdy));
            chk("core_start", 128'(core_start), 128'(m_job && cyc == j_t + 1));
            chk("rsp_valid", 128'(rsp_valid),
                128'(m_job && !hang && (m_seen || cyc == j_t + 14)));
            if (m_job && cyc > j_t) begin
                chk("core_pt", core_pt, j_pt);
                chk("core_key", core_key, j_key);
            end
            if (m_job && rsp_valid) begin
                chk("rsp_id", 128'(rsp_id), 128'(j_id));
                chk("rsp_data", rsp_data, j_ct);
            end
            // model updates for the next cycle
            if (m_boot && core_finish) begin m_boot = 0; m_busy = 0; end
`ifdef AES_ARB_WDOG_EN
            if (hang && m_job && cyc == j_t + 1 + WDOG) begin m_job = 0; m_boot = 1; end
`endif
            if (g >= 0) begin
                m_busy = 1; m_job = 1; m_seen = 0; m_ptr = g;
                j_id = g; j_pt = req_pt[g]; j_key = req_key[g];
                j_ct = aes_enc(j_pt, j_key); j_t = cyc;
                grant_log.push_back(g);
            end
            if (m_job && rsp_valid && rsp_ready) begin m_job = 0; m_busy = 0; end
            else if (rsp_valid) m_seen = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(input int maxc);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < maxc);
        if (!rsp_valid) chk("wait_rsp_timeout", 128'(rsp_valid), 128'(1));
    endtask

    task automatic wait_grant(input int maxc, output int gi);
        int n;
        n = 0; gi = -1;
        do begin @(negedge clk); n++; end while (req_ready == '0 && n < maxc);
        if (req_ready == '0) chk("wait_grant_timeout", 128'(req_ready), 128'(1));
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi = i;
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_id", 128'(rsp_id), 128'(0));
        chk("rst_rsp_data", rsp_data, 128'(0));
        chk("rst_core_start", 128'(core_start), 128'(0));
        chk("rst_core_pt", core_pt, 128'(0));
        chk("rst_core_key", core_key, 128'(0));
`ifdef AES_ARB_WDOG_EN
        chk("rst_wdog_err", 128'(wdog_err), 128'(0));
`endif
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        nrst = 1'b0; hang = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        tick();
        nrst = 1'b1;
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};
    int gi, t0, starts, lat, hid;
    logic [127:0] hdata;

    initial begin
        req_valid = '0; req_pt = '0; req_key = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        tick();
        nrst = 1'b1;

        // 1: known-answer vector through requester 0
        req_pt[0]  = 128'h00112233445566778899aabbccddeeff;
        req_key[0] = 128'h000102030405060708090a0b0c0d0e0f;
        req_valid  = 4'b0001;
        wait_rsp(80);
        chk("t1_id", 128'(rsp_id), 128'(0));
        chk("t1_ct", rsp_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        tick(); req_valid = '0;

        // 2: all requesting after reset, order starts at 0
        do_reset();
        grant_log.delete();
        for (int i = 0; i < NREQ; i++) begin
            req_pt[i] = {$urandom, $urandom, $urandom, $urandom};
            req_key[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        req_valid = 4'b1111;
        for (int n = 0; n < 300 && grant_log.size() < 5; n++) @(negedge clk);
        chk("t2_grants", 128'(grant_log.size() >= 5), 128'(1));
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk("t2_order", 128'(grant_log[i]), 128'(exp_order[i]));

        // 3: single job latency and one-cycle start
        tick(); req_valid = 4'b0010;
        do wait_grant(100, gi); while (gi != 1 && gi >= 0);
        t0 = cyc; starts = 0; lat = 0;
        for (int n = 0; n < 40 && !rsp_valid; n++) begin
            @(negedge clk);
            if (core_start) starts++;
        end
        lat = cyc - t0;
        chk("t3_latency", 128'(lat), 128'(14));
        chk("t3_start_cycles", 128'(starts), 128'(1));

        // 4: backpressure 30 cycles, then next grant follows round-robin
        tick(); req_valid = 4'b1111; rsp_ready = 1'b0;
        wait_rsp(60);
        hid = rsp_id; hdata = rsp_data;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            chk("t4_hold_valid", 128'(rsp_valid), 128'(1));
            chk("t4_hold_id", 128'(rsp_id), 128'(hid));
            chk("t4_hold_data", rsp_data, hdata);
            chk("t4_no_ready", 128'(req_ready), 128'(0));
        end
        tick(); rsp_ready = 1'b1;
        wait_grant(20, gi);
        chk("t4_next_grant", 128'(gi), 128'((hid + 1) % NREQ));

        // 5: reset in BUSY, then a clean job
        tick(); req_valid = 4'b0100;
        do wait_grant(100, gi); while (gi != 2 && gi >= 0);
        repeat (5) @(posedge clk);
        do_reset();
        wait_rsp(80);
        chk("t5_id", 128'(rsp_id), 128'(2));
        chk("t5_ct", rsp_data, aes_enc(req_pt[2], req_key[2]));

        // 6: random traffic against the scoreboard
        for (int n = 0; n < 900; n++) begin
            tick();
            if ($urandom_range(0, 3) == 0) req_valid = 4'($urandom_range(0, 15));
            req_pt[$urandom_range(0, NREQ-1)]  = {$urandom, $urandom, $urandom, $urandom};
            req_key[$urandom_range(0, NREQ-1)] = {$urandom, $urandom, $urandom, $urandom};
            rsp_ready = ($urandom_range(0, 9) < 7);
        end
        tick(); req_valid = '0; rsp_ready = 1'b1;
        repeat (20) @(negedge clk);

`ifdef AES_ARB_WDOG_EN
        // 7: core hangs after launch, watchdog fires after 20 BUSY cycles
        do_reset();
        req_valid = 4'b0001;
        wait_grant(60, gi);
        t0 = cyc;
        tick(); hang = 1'b1; req_valid = '0;
        while (cyc < t0 + 21) @(negedge clk);
        chk("t7_wdog_early", 128'(wdog_err), 128'(0));
        @(negedge clk);
        chk("t7_wdog_fire", 128'(wdog_err), 128'(1));
        repeat (10) @(negedge clk);
        chk("t7_wdog_sticky", 128'(wdog_err), 128'(1));
        chk("t7_no_rsp", 128'(rsp_valid), 128'(0));
        do_reset();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
